// File: rtl/audio_sdm2.sv
// Second-order sigma-delta audio DAC for one channel.
// Level soft-ramps after reset and on mute edges so the output never steps abruptly.
module audio_sdm2 #(
  parameter int C_bits   = 16,
  parameter int RAMP_DIV = 2
) (
  input  logic              clk_i,
  input  logic              res_n_i,
  input  logic [C_bits-1:0] dac_i,
  input  logic              load_i,
  input  logic              mute_i,
  output logic              dac_o,
  output logic              ramp_o
);

  localparam int W = C_bits + 4;

  localparam logic [C_bits-1:0] MID    = {1'b1, {(C_bits-1){1'b0}}};
  localparam logic [C_bits-1:0] LVL_LO = {4'b0001, {(C_bits-4){1'b0}}};
  localparam logic [C_bits-1:0] LVL_HI = {4'b1111, {(C_bits-4){1'b0}}};

  localparam logic signed [W-1:0] FB_POS = {5'b00001, {(C_bits-1){1'b0}}};
  localparam logic signed [W-1:0] FB_NEG = {5'b11111, {(C_bits-1){1'b0}}};
  localparam logic signed [W:0]   SAT_HI = {3'b000, {(C_bits+2){1'b1}}};
  localparam logic signed [W:0]   SAT_LO = {3'b111, {(C_bits+2){1'b0}}};

  typedef enum logic {
    RAMP  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [C_bits-1:0]   x;
  logic [C_bits-1:0]   lvl, lvl_next;
  logic [C_bits-1:0]   tgt;
  logic [C_bits-1:0]   clamped;
  logic                mute_q;
  logic                tick;
  logic signed [W-1:0] i1, i2;
  logic signed [W-1:0] u, fb;
  logic signed [W:0]   i1_sum, i2_sum;
  logic signed [W-1:0] i1_next, i2_next;

  function automatic logic signed [W-1:0] sat(input logic signed [W:0] v);
    if (v > SAT_HI)
      sat = SAT_HI[W-1:0];
    else if (v < SAT_LO)
      sat = SAT_LO[W-1:0];
    else
      sat = v[W-1:0];
  endfunction

  generate
    if (RAMP_DIV == 0) begin : g_no_div
      assign tick = 1'b1;
    end else begin : g_div
      logic [RAMP_DIV-1:0] tick_cnt;
      always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i)
          tick_cnt <= '0;
        else
          tick_cnt <= tick_cnt + 1'b1;
      end
      assign tick = &tick_cnt;
    end
  endgenerate

  // Samples are held in offset binary so the level ramp is plain unsigned arithmetic.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      x      <= MID;
      mute_q <= 1'b0;
    end else begin
      mute_q <= mute_i;
      if (load_i)
        x <= {~dac_i[C_bits-1], dac_i[C_bits-2:0]};
    end
  end

  assign tgt = mute_i ? MID : x;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state  <= RAMP;
      lvl    <= '0;
      ramp_o <= 1'b1;
    end else begin
      state  <= state_next;
      lvl    <= lvl_next;
      ramp_o <= (state_next == RAMP);
    end
  end

  // On a mute edge the level is held for that cycle so the ramp starts from where tracking left off.
  always_comb begin
    state_next = state;
    lvl_next   = lvl;
    case (state)
      RAMP: begin
        if (tick) begin
          if (lvl == tgt)
            state_next = TRACK;
          else if (lvl < tgt)
            lvl_next = lvl + 1'b1;
          else
            lvl_next = lvl - 1'b1;
        end
      end
      TRACK: begin
        if (mute_i != mute_q)
          state_next = RAMP;
        else
          lvl_next = tgt;
      end
      default: begin
        state_next = RAMP;
        lvl_next   = '0;
      end
    endcase
  end

  // Clamping away from the rails keeps the second-order loop stable.
  always_comb begin
    if (lvl < LVL_LO)
      clamped = LVL_LO;
    else if (lvl > LVL_HI)
      clamped = LVL_HI;
    else
      clamped = lvl;
  end

  always_comb begin
    u       = {4'b0000, clamped} - FB_POS;
    fb      = dac_o ? FB_POS : FB_NEG;
    i1_sum  = {i1[W-1], i1} + {u[W-1], u} - {fb[W-1], fb};
    i2_sum  = {i2[W-1], i2} + {i1[W-1], i1} - {fb[W-1], fb};
    i1_next = sat(i1_sum);
    i2_next = sat(i2_sum);
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      i1    <= '0;
      i2    <= '0;
      dac_o <= 1'b0;
    end else begin
      i1    <= i1_next;
      i2    <= i2_next;
      dac_o <= ~i2_next[W-1];
    end
  end

endmodule

// File: tb/tb_audio_sdm2.sv
// Directed bench for audio_sdm2 at C_bits=8, RAMP_DIV=2 (midscale 0x80, ramp tick every 4 clocks).
module tb_audio_sdm2;

  logic       clk_sys;
  logic       res_n;
  logic [7:0] dac_in;
  logic       load;
  logic       mute;
  logic       pdm;
  logic       ramp;

  int checks;
  int failures;

  audio_sdm2 #(
    .C_bits  (8),
    .RAMP_DIV(2)
  ) dut (
    .clk_i  (clk_sys),
    .res_n_i(res_n),
    .dac_i  (dac_in),
    .load_i (load),
    .mute_i (mute),
    .dac_o  (pdm),
    .ramp_o (ramp)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_ramp(output int n, output bit done);
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk_sys);
      #1;
      if (!ramp) begin
        done = 1'b1;
        break;
      end
      n++;
    end
  endtask

  task automatic measure(output int ones, output int i_min, output int i_max);
    ones  = 0;
    i_min = 0;
    i_max = 0;
    for (int k = 0; k < 4096; k++) begin
      @(negedge clk_sys);
      ones += int'(pdm);
      if (int'(dut.i1) < i_min) i_min = int'(dut.i1);
      if (int'(dut.i2) < i_min) i_min = int'(dut.i2);
      if (int'(dut.i1) > i_max) i_max = int'(dut.i1);
      if (int'(dut.i2) > i_max) i_max = int'(dut.i2);
    end
  endtask

  task automatic load_sample(input logic [7:0] v);
    @(negedge clk_sys);
    dac_in = v;
    load   = 1'b1;
    @(negedge clk_sys);
    load   = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    bit done;
    res_n  = 1'b0;
    load   = 1'b0;
    mute   = 1'b0;
    dac_in = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if (pdm !== 1'b0) begin failures++; $display("[TB] FAIL reset_dac_o: got %0b expected 0", pdm); end
    checks++;
    if (ramp !== 1'b1) begin failures++; $display("[TB] FAIL reset_ramp_o: got %0b expected 1", ramp); end
    checks++;
    if (dut.lvl !== 8'h00) begin failures++; $display("[TB] FAIL reset_lvl: got %h expected 00", dut.lvl); end
    checks++;
    if (dut.x !== 8'h80) begin failures++; $display("[TB] FAIL reset_x: got %h expected 80", dut.x); end
    @(negedge clk_sys);
    res_n = 1'b1;
    wait_ramp(n, done);
    checks++;
    if (!done || n < 508 || n > 516) begin
      failures++;
      $display("[TB] FAIL reset_ramp_len: got %0d (done=%0b) expected 508..516", n, done);
    end
    checks++;
    if (dut.lvl !== 8'h80) begin failures++; $display("[TB] FAIL reset_ramp_end_lvl: got %h expected 80", dut.lvl); end
  endtask

  task automatic test_density_mid;
    int ones, lo, hi;
    repeat (64) @(negedge clk_sys);
    measure(ones, lo, hi);
    checks++;
    if (ones < 2028 || ones > 2068) begin
      failures++;
      $display("[TB] FAIL density_mid: got %0d ones expected 2048+-20", ones);
    end
  endtask

  task automatic test_load_latency;
    int ones, lo, hi;
    @(negedge clk_sys);
    dac_in = 8'h40;
    load   = 1'b1;
    @(posedge clk_sys);
    #1;
    checks++;
    if (dut.x !== 8'hC0) begin failures++; $display("[TB] FAIL load_x: got %h expected c0", dut.x); end
    checks++;
    if (dut.lvl !== 8'h80) begin failures++; $display("[TB] FAIL load_lvl_early: got %h expected 80", dut.lvl); end
    @(negedge clk_sys);
    load = 1'b0;
    @(posedge clk_sys);
    #1;
    checks++;
    if (dut.lvl !== 8'hC0) begin failures++; $display("[TB] FAIL load_lvl_track: got %h expected c0", dut.lvl); end
    repeat (64) @(negedge clk_sys);
    measure(ones, lo, hi);
    checks++;
    if (ones < 3052 || ones > 3092) begin
      failures++;
      $display("[TB] FAIL density_75: got %0d ones expected 3072+-20", ones);
    end
  endtask

  task automatic test_full_scale;
    int ones, lo, hi;
    load_sample(8'h7F);
    repeat (64) @(negedge clk_sys);
    measure(ones, lo, hi);
    checks++;
    if (ones < 3820 || ones > 3860) begin
      failures++;
      $display("[TB] FAIL density_pos_full: got %0d ones expected 3840+-20", ones);
    end
    checks++;
    if (lo < -1024 || hi > 1023) begin
      failures++;
      $display("[TB] FAIL integ_range_pos: got %0d..%0d expected within -1024..1023", lo, hi);
    end
    load_sample(8'h80);
    repeat (64) @(negedge clk_sys);
    measure(ones, lo, hi);
    checks++;
    if (ones < 236 || ones > 276) begin
      failures++;
      $display("[TB] FAIL density_neg_full: got %0d ones expected 256+-20", ones);
    end
    checks++;
    if (lo < -1024 || hi > 1023) begin
      failures++;
      $display("[TB] FAIL integ_range_neg: got %0d..%0d expected within -1024..1023", lo, hi);
    end
  endtask

  task automatic test_mute;
    int n, gap;
    bit done, bad;
    logic [7:0] prev;
    load_sample(8'h40);
    repeat (8) @(negedge clk_sys);
    prev = dut.lvl;
    bad  = 1'b0;
    n    = 0;
    gap  = 100;
    done = 1'b0;
    mute = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk_sys);
      #1;
      gap++;
      if (dut.lvl != prev) begin
        if (dut.lvl > prev || (prev - dut.lvl) != 8'd1 || gap < 4) bad = 1'b1;
        gap = 0;
      end
      prev = dut.lvl;
      if (!ramp) begin
        done = 1'b1;
        break;
      end
      n++;
    end
    checks++;
    if (!done || n < 252 || n > 260) begin
      failures++;
      $display("[TB] FAIL mute_ramp_len: got %0d (done=%0b) expected 252..260", n, done);
    end
    checks++;
    if (bad) begin failures++; $display("[TB] FAIL mute_step: got irregular steps expected -1 per 4 clocks"); end
    checks++;
    if (dut.lvl !== 8'h80) begin failures++; $display("[TB] FAIL mute_end_lvl: got %h expected 80", dut.lvl); end
    @(negedge clk_sys);
    mute = 1'b0;
    wait_ramp(n, done);
    checks++;
    if (!done || n < 252 || n > 260) begin
      failures++;
      $display("[TB] FAIL unmute_ramp_len: got %0d (done=%0b) expected 252..260", n, done);
    end
    checks++;
    if (dut.lvl !== 8'hC0) begin failures++; $display("[TB] FAIL unmute_end_lvl: got %h expected c0", dut.lvl); end
  endtask

  task automatic test_back_to_back;
    int n;
    bit done;
    @(negedge clk_sys);
    mute   = 1'b1;
    load   = 1'b1;
    dac_in = 8'h00;
    @(posedge clk_sys);
    #1;
    checks++;
    if (ramp !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ramp: got %0b expected 1", ramp); end
    checks++;
    if (dut.x !== 8'h80) begin failures++; $display("[TB] FAIL b2b_x: got %h expected 80", dut.x); end
    @(negedge clk_sys);
    load = 1'b0;
    wait_ramp(n, done);
    checks++;
    if (!done || dut.lvl !== 8'h80) begin
      failures++;
      $display("[TB] FAIL b2b_end_lvl: got %h (done=%0b) expected 80", dut.lvl, done);
    end
  endtask

  task automatic test_reversal;
    int n;
    bit done, reached;
    logic [7:0] peak;
    @(negedge clk_sys);
    res_n = 1'b0;
    mute  = 1'b0;
    @(negedge clk_sys);
    res_n   = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_sys);
      if (dut.lvl >= 8'h20) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin failures++; $display("[TB] FAIL rev_reach: got lvl %h expected >= 20", dut.lvl); end
    dac_in = 8'h80;
    load   = 1'b1;
    @(negedge clk_sys);
    load = 1'b0;
    peak = dut.lvl;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk_sys);
      #1;
      if (dut.lvl > peak) peak = dut.lvl;
      if (!ramp) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (peak > 8'h21) begin failures++; $display("[TB] FAIL rev_peak: got %h expected <= 21", peak); end
    checks++;
    if (!done || dut.lvl !== 8'h00) begin
      failures++;
      $display("[TB] FAIL rev_end_lvl: got %h (done=%0b) expected 00", dut.lvl, done);
    end
    n = 0;
  endtask

  task automatic test_async_reset;
    bit seen;
    load_sample(8'h40);
    seen = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_sys);
      if (pdm === 1'b1 && ramp === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL areset_setup: got dac_o %0b ramp_o %0b expected 1/0", pdm, ramp); end
    #2;
    res_n = 1'b0;
    #1;
    checks++;
    if (pdm !== 1'b0 || ramp !== 1'b1) begin
      failures++;
      $display("[TB] FAIL areset_outputs: got dac_o %0b ramp_o %0b expected 0/1", pdm, ramp);
    end
    checks++;
    if (dut.lvl !== 8'h00) begin failures++; $display("[TB] FAIL areset_lvl: got %h expected 00", dut.lvl); end
    @(negedge clk_sys);
    res_n = 1'b1;
    repeat (40) @(posedge clk_sys);
    #1;
    checks++;
    if (dut.lvl !== 8'd10 || ramp !== 1'b1) begin
      failures++;
      $display("[TB] FAIL areset_restart: got lvl %0d ramp_o %0b expected 10/1", dut.lvl, ramp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    $display("[TB] audio_sdm2 directed tests");
    test_reset();
    test_density_mid();
    test_load_latency();
    test_full_scale();
    test_mute();
    test_back_to_back();
    test_reversal();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
